// File: rtl/pix_tx.sv
// rtl/pix_tx.sv - PIX bus transmitter: queued write requests serialized as 32-bit frames on a 4-bit DDR bus.
// Build option PIX_TX_FIFO_EN selects a DEPTH-entry request FIFO; otherwise a single holding register.
module pix_tx #(
  parameter int HALF_DIV = 2,
  parameter int DEPTH    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_device,
  input  logic [3:0]  req_channel,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        phi2_out,
  output logic [3:0]  pix_out,
  output logic        busy,
  output logic        frame_sent
);

  localparam int CW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(HALF_DIV - 1);
  // Launch edge leaves the counter at HALF_DIV/2, mid-way between phi2 edges.
  localparam logic [CW-1:0] SLOT_CNT = CW'(HALF_DIV / 2 - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phi2_q, phi2_d;
  logic          slot;
  state_t        state_q, state_d;
  logic [3:0]    pix_q, pix_d;
  logic [27:0]   shift_q, shift_d;
  logic [2:0]    nib_q, nib_d;
  logic          sent_q, sent_d;

  logic          push, pop, q_empty, ready_q;
  logic [31:0]   q_head, req_frame;

  assign req_frame = {req_device, 1'b1, req_channel, req_addr, req_data};
  assign push      = req_valid && ready_q;

`ifdef PIX_TX_FIFO_EN
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= req_frame;
  end

  assign q_empty = (count_q == '0);
  assign q_head  = mem[rd_ptr_q];
`else
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_q;
  logic        unused_depth;

  assign unused_depth = (DEPTH == 0);

  // Push and pop never coincide: ready is only high while the register is empty.
  always_comb begin
    hold_valid_d = hold_valid_q;
    if (push)     hold_valid_d = 1'b1;
    else if (pop) hold_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ready_q      <= !hold_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) hold_q <= req_frame;
  end

  assign q_empty = !hold_valid_q;
  assign q_head  = hold_q;
`endif

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    phi2_d = (cnt_q == CNT_MAX) ? !phi2_q : phi2_q;
  end

  assign slot = (cnt_q == SLOT_CNT);

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    shift_d = shift_q;
    nib_d   = nib_q;
    sent_d  = 1'b0;
    pop     = 1'b0;
    if (slot) begin
      case (state_q)
        S_IDLE: begin
          // Nibble 0 must precede a falling phi2 edge, so start only while phi2 is high.
          if (phi2_q && !q_empty) begin
            pop     = 1'b1;
            state_d = S_SEND;
            pix_d   = q_head[31:28];
            shift_d = q_head[27:0];
            nib_d   = 3'd0;
          end else begin
            pix_d = 4'hF;
          end
        end
        S_SEND: begin
          if (nib_q != 3'd7) begin
            pix_d   = shift_q[27:24];
            shift_d = {shift_q[23:0], 4'hF};
            nib_d   = nib_q + 3'd1;
            sent_d  = (nib_q == 3'd6);
          end else if (!q_empty) begin
            pop     = 1'b1;
            pix_d   = q_head[31:28];
            shift_d = q_head[27:0];
            nib_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
            pix_d   = 4'hF;
          end
        end
        default: begin
          state_d = S_IDLE;
          pix_d   = 4'hF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phi2_q  <= 1'b0;
      state_q <= S_IDLE;
      pix_q   <= 4'hF;
      shift_q <= '0;
      nib_q   <= 3'd0;
      sent_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phi2_q  <= phi2_d;
      state_q <= state_d;
      pix_q   <= pix_d;
      shift_q <= shift_d;
      nib_q   <= nib_d;
      sent_q  <= sent_d;
    end
  end

  assign req_ready  = ready_q;
  assign phi2_out   = phi2_q;
  assign pix_out    = pix_q;
  assign frame_sent = sent_q;
  assign busy       = !q_empty || (state_q == S_SEND);

endmodule

// File: tb/tb_pix_tx.sv
// tb/tb_pix_tx.sv - directed self-checking bench for pix_tx with a reference PIX receiver.
module tb_pix_tx;

  localparam int HD  = 2;
  localparam int DEP = 16;
`ifdef PIX_TX_FIFO_EN
  localparam int NBURST = 20;
`else
  localparam int NBURST = 6;
`endif
  localparam int LIM = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_device;
  logic [3:0]  req_channel;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        phi2_out;
  logic [3:0]  pix_out;
  logic        busy;
  logic        frame_sent;

  pix_tx #(.HALF_DIV(HD), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_device (req_device),
    .req_channel(req_channel),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .phi2_out   (phi2_out),
    .pix_out    (pix_out),
    .busy       (busy),
    .frame_sent (frame_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic        prev_phi2 = 1'b0;
  logic [3:0]  prev_pix = 4'hF;
  logic        prev_fs = 1'b0;
  int          viol = 0;
  int          fs_count = 0;
  int          fs_wide = 0;
  logic [3:0]  fs_nib = 4'h0;
  int          n_launch = 0;
  int          launch_cyc = 0;
  int          edge_cnt = 0;
  logic        rx_active = 1'b0;
  logic [31:0] rx_sh = '0;
  int          rx_n = 0;
  int          rx_start = 0;
  logic [31:0] rx_q[$];
  int          rx_edge[$];
  logic        burst_watch = 1'b0;
  int          burst_target = 0;
  int          busy_gap = 0;
  logic        saw_nready = 1'b0;
  int          acc_cyc = 0;

  // Reference receiver: even nibbles on falling phi2, odd on rising; F on a falling edge means idle.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      rx_active = 1'b0;
    end else begin
      if (phi2_out !== prev_phi2 && pix_out !== prev_pix) viol++;
      if (frame_sent === 1'b1) begin
        fs_count++;
        fs_nib = pix_out;
        if (prev_fs === 1'b1) fs_wide++;
      end
      if (prev_pix == 4'hF && pix_out != 4'hF) begin
        n_launch++;
        launch_cyc = cyc;
      end
      if (phi2_out != prev_phi2) begin
        if (rx_active) begin
          rx_sh = {rx_sh[27:0], pix_out};
          rx_n++;
          if (rx_n == 8) begin
            rx_q.push_back(rx_sh);
            rx_edge.push_back(rx_start);
            rx_active = 1'b0;
          end
        end else if (prev_phi2 && !phi2_out && pix_out != 4'hF) begin
          rx_active = 1'b1;
          rx_sh = {28'h0, pix_out};
          rx_n = 1;
          rx_start = edge_cnt;
        end
        edge_cnt++;
      end
      if (burst_watch && !busy && rx_q.size() < burst_target) busy_gap++;
      if (req_valid && !req_ready) saw_nready = 1'b1;
    end
    prev_phi2 = phi2_out;
    prev_pix  = pix_out;
    prev_fs   = frame_sent;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] d, input logic [3:0] c, input logic [7:0] a,
                      input logic [15:0] v);
    int t;
    req_device  = d;
    req_channel = c;
    req_addr    = a;
    req_data    = v;
    req_valid   = 1'b1;
    t = 0;
    while (!req_ready && t < LIM) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", (t < LIM), 1);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 20 * LIM) begin
      @(negedge clk);
      t++;
    end
    check("rx_timeout", (t < 20 * LIM), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < LIM) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t < LIM), 1);
    repeat (4 * HD) @(negedge clk);
  endtask

  function automatic logic [31:0] burst_frame(input int i);
    logic [2:0]  d;
    logic [3:0]  c;
    logic [7:0]  a;
    logic [15:0] v;
    d = 3'(i % 7);
    c = 4'(i % 16);
    a = 8'(i * 17);
    v = 16'hA500 + 16'(i);
    return {d, 1'b1, c, a, v};
  endfunction

  initial begin
    int base, fs0, n0, t, bad, acc_a, acc_b, nl_before, rx_before;

    // Reset with a pending request.
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_device = 3'd2;
    req_channel = 4'd0;
    req_addr = 8'h00;
    req_data = 16'h0001;
    repeat (4) @(negedge clk);
    check("rst_pix", pix_out, 4'hF);
    check("rst_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_phi2", phi2_out, 1'b0);
    check("rst_fs", frame_sent, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", req_ready, 1'b1);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("no_accept_in_reset", busy, 1'b0);

    // Single config write.
    base = rx_q.size();
    fs0 = fs_count;
    n0 = n_launch;
    send(3'd2, 4'd0, 8'h00, 16'h0001);
    t = 0;
    while (n_launch == n0 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    check("launch_latency", ((launch_cyc - acc_cyc) >= 1) && ((launch_cyc - acc_cyc) <= 2 * HD), 1);
    wait_rx(base + 1);
    check("cfg_frame", rx_q[base], 32'h5000_0001);
    wait_idle();
    check("cfg_idle_pix", pix_out, 4'hF);
    check("cfg_fs_count", fs_count - fs0, 1);
    check("cfg_fs_nibble7", fs_nib, 4'h1);

    // XRAM write.
    base = rx_q.size();
    send(3'd0, 4'd0, 8'h3C, 16'hFF00);
    wait_rx(base + 1);
    check("xram_frame", rx_q[base], 32'h103C_FF00);
    wait_idle();
    check("xram_fs_nibble7", fs_nib, 4'h0);
    check("xram_busy", busy, 1'b0);

    // Burst with valid held high.
    base = rx_q.size();
    fs0 = fs_count;
    saw_nready = 1'b0;
    busy_gap = 0;
    burst_target = base + NBURST;
    for (int i = 0; i < NBURST; i++) begin
      logic [31:0] f;
      f = burst_frame(i);
      send(f[31:29], f[27:24], f[23:16], f[15:0]);
      burst_watch = 1'b1;
    end
    wait_rx(base + NBURST);
    for (int i = 0; i < NBURST; i++) check($sformatf("burst_frame_%0d", i), rx_q[base + i], burst_frame(i));
    bad = 0;
    for (int i = 1; i < NBURST; i++) if (rx_edge[base + i] - rx_edge[base + i - 1] != 8) bad++;
    check("burst_back_to_back", bad, 0);
    check("burst_ready_dropped", saw_nready, 1'b1);
    check("burst_busy_gap", busy_gap, 0);
    wait_idle();
    burst_watch = 1'b0;
    check("burst_fs_count", fs_count - fs0, NBURST);

    // Two requests back-to-back: acceptance of the second depends on the build.
    base = rx_q.size();
    n0 = n_launch;
    send(3'd3, 4'd5, 8'h12, 16'h3456);
    acc_a = acc_cyc;
    send(3'd1, 4'd2, 8'hAB, 16'hCDEF);
    acc_b = acc_cyc;
    t = 0;
    while (n_launch == n0 && t < LIM) begin
      @(negedge clk);
      t++;
    end
`ifdef PIX_TX_FIFO_EN
    check("second_accept", acc_b, acc_a + 1);
`else
    check("second_accept", acc_b, launch_cyc + 1);
`endif
    wait_rx(base + 2);
    check("pair_frame_a", rx_q[base], 32'h7512_3456);
    check("pair_frame_b", rx_q[base + 1], 32'h32AB_CDEF);
    check("pair_back_to_back", rx_edge[base + 1] - rx_edge[base], 8);
    wait_idle();

    // Reset during nibble 3 of a queued pair.
    n0 = n_launch;
    send(3'd3, 4'd5, 8'h12, 16'h3456);
    send(3'd1, 4'd2, 8'hAB, 16'hCDEF);
    t = 0;
    while (n_launch == n0 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (cyc < launch_cyc + 3 * HD && t < LIM) begin
      @(negedge clk);
      t++;
    end
    check("mid_nibble3", pix_out, 4'h2);
    rx_before = rx_q.size();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_pix", pix_out, 4'hF);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    nl_before = n_launch;
    repeat (40) @(negedge clk);
    check("mid_no_frames", rx_q.size(), rx_before);
    check("mid_no_launch", n_launch, nl_before);
    check("mid_pix_idle", pix_out, 4'hF);
    check("mid_ready", req_ready, 1'b1);

    check("setup_hold_violations", viol, 0);
    check("frame_sent_width", fs_wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
